ibex_obi_mem_responder: RTL and testbench

- Memory-side responder for the Ibex core's request/grant/rvalid bus (OBI-style): word-addressed single-port RAM that answers instruction-fetch or data requests in order, with a fixed, configurable response latency.
- One instance serves the instruction port and another serves the data port of the core wrapper.
- A backdoor load port lets the bench preload program images while the core is held in reset.

---
 rtl/ibex_obi_mem_responder.sv | 121 ++++++++++++
 tb/tb_ibex_obi_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_obi_mem_responder.sv
// Purpose : word-addressed single-port RAM answering OBI req/gnt/rvalid traffic in order, with a backdoor preload port.
// Latency : rvalid_o rises exactly Latency cycles after the grant cycle; reads see same-edge backdoor writes.
// Backpr. : no rready; accepted requests are throttled by gnt_o once MaxOutstanding responses are in flight.
//
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset (RAM contents are kept)
//   req_i/gnt_o                         request valid / accepted this cycle (gnt_o is combinational)
//   addr_i, we_i, be_i, wdata_i         byte address, write enable, byte enables, write data
//   rvalid_o, rdata_o, err_o            in-order response; rdata_o/err_o are 0 whenever rvalid_o is 0
//   load_we_i, load_addr_i, load_wdata_i backdoor word write (word index, not byte address)
module ibex_obi_mem_responder #(
    parameter int          MemWords       = 4096,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int AW = $clog2(MemWords);
    // One extra bit so the span is representable even for a 4 GiB memory.
    localparam logic [32:0] SpanBytes = 33'(MemWords) << 2;

    logic [31:0]         r_mem [MemWords];
    logic [2:0]          r_count;
    logic [Latency-1:0]  r_pipe_vld;
    logic [Latency-1:0]  r_pipe_err;
    logic [31:0]         r_pipe_dat [Latency];

    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_load_idx;
    logic          w_retire;
    logic          w_accept;
    logic          w_bus_we;
    logic [31:0]   w_mem_rd;
    logic [31:0]   w_rsp_dat;
    logic          w_rsp_err;
    logic          w_unused_load_addr;

    // Wrapping subtraction: addresses below BaseAddr land far above the span and decode as errors.
    assign w_off      = addr_i - BaseAddr;
    assign w_in_range = {1'b0, w_off} < SpanBytes;
    assign w_idx      = w_off[AW+1:2];
    assign w_load_idx = load_addr_i[AW-1:0];
    assign w_unused_load_addr = ^load_addr_i[31:AW];

    // A response leaving the pipe this cycle frees a slot for a same-cycle grant.
    assign w_retire = rvalid_o;
    assign gnt_o    = rst_ni & req_i & ((r_count < 3'(MaxOutstanding)) | w_retire);
    assign w_accept = req_i & gnt_o;
    assign w_bus_we = w_accept & we_i & w_in_range;

    // Bus write first, backdoor second: the later non-blocking write wins on a same-word collision.
    always_ff @(posedge clk_i) begin
        if (w_bus_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
        if (load_we_i) begin
            r_mem[w_load_idx] <= load_wdata_i;
        end
    end

    // A read granted on the same edge as a backdoor write to its word returns the new value.
    assign w_mem_rd  = (load_we_i && (w_load_idx == w_idx)) ? load_wdata_i : r_mem[w_idx];
    assign w_rsp_dat = (w_accept && !we_i && w_in_range) ? w_mem_rd : 32'h0;
    assign w_rsp_err = w_accept & ~w_in_range;

    // Empty slots carry zeros, so the output stage is 0 whenever rvalid_o is low.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pipe_vld <= '0;
            r_pipe_err <= '0;
            for (int i = 0; i < Latency; i++) begin
                r_pipe_dat[i] <= 32'h0;
            end
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_err[0] <= w_rsp_err;
            r_pipe_dat[0] <= w_rsp_dat;
            for (int i = 1; i < Latency; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_err[i] <= r_pipe_err[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= 3'd0;
        end else if (w_accept && !w_retire) begin
            r_count <= r_count + 3'd1;
        end else if (!w_accept && w_retire) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign rvalid_o = r_pipe_vld[Latency-1];
    assign err_o    = r_pipe_err[Latency-1];
    assign rdata_o  = r_pipe_dat[Latency-1];

endmodule

// File: tb/tb_ibex_obi_mem_responder.sv
module tb_ibex_obi_mem_responder;

    localparam int MAXO = 2;

    typedef struct packed {
        logic        rst;
        logic        req;
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        lwe;
        logic [31:0] la;
        logic [31:0] lwd;
    } stim_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n  [2];
    logic        req    [2];
    logic        gnt    [2];
    logic [31:0] addr   [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];
    logic        lwe    [2];
    logic [31:0] la     [2];
    logic [31:0] lwd    [2];

    ibex_obi_mem_responder #(.MemWords(4096), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(MAXO)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .load_we_i(lwe[0]), .load_addr_i(la[0]), .load_wdata_i(lwd[0])
    );

    ibex_obi_mem_responder #(.MemWords(4096), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(MAXO)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .load_we_i(lwe[1]), .load_addr_i(la[1]), .load_wdata_i(lwd[1])
    );

    // Reference model: plain word array per instance plus an in-order queue of expected responses.
    logic [31:0] mdl [2][4096];
    exp_t        sbq [2][$];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic rq, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] wd);
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        s.req = rq;
        s.we  = w;
        s.a   = a;
        s.be  = b;
        s.wd  = wd;
        return s;
    endfunction

    // One bus cycle: drive after the edge, judge the grant mid-cycle, update model for the coming edge.
    task automatic drive(input int d, input stim_t s, output bit g);
        logic        inr;
        logic [11:0] idx;
        logic        eg;
        exp_t        e;
        @(posedge clk);
        #1;
        rst_n[d] = s.rst; req[d] = s.req; we[d] = s.we; addr[d] = s.a; be[d] = s.be;
        wdata[d] = s.wd; lwe[d] = s.lwe; la[d] = s.la; lwd[d] = s.lwd;
        @(negedge clk);
        // A slot is free if fewer than MAXO responses are pending or the oldest one leaves this cycle.
        eg = s.req && s.rst && ((sbq[d].size() < MAXO) || ((sbq[d].size() > 0) && (sbq[d][0].due == cyc)));
        chk("gnt", d, 64'(gnt[d]), 64'(eg));
        g   = s.req && s.rst && gnt[d];
        inr = s.a < 32'h0000_4000;
        idx = s.a[13:2];
        if (g && s.we && inr) begin
            for (int k = 0; k < 4; k++) begin
                if (s.be[k]) mdl[d][idx][8*k +: 8] = s.wd[8*k +: 8];
            end
        end
        if (s.lwe) mdl[d][s.la[11:0]] = s.lwd;
        if (g) begin
            e.due = cyc + lat(d);
            e.err = !inr;
            e.dat = (!s.we && inr) ? mdl[d][idx] : 32'h0;
            sbq[d].push_back(e);
        end
    endtask

    task automatic xact(input int d, input stim_t s, output int tries);
        bit g;
        g = 1'b0;
        tries = 0;
        while (!g && tries < 20) begin
            drive(d, s, g);
            tries++;
        end
        chk("granted", d, 64'(g), 64'd1);
    endtask

    task automatic idle(input int d, input int n);
        bit g;
        for (int i = 0; i < n; i++) drive(d, mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0), g);
    endtask

    // A reset edge drops every in-flight response.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) sbq[d].delete();
        end
    end

    // Monitor: pops and compares whenever a response is due or presented.
    initial begin
        exp_t e;
        logic ev;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                ev = (sbq[d].size() > 0) && (sbq[d][0].due <= cyc);
                chk("rvalid", d, 64'(rvalid[d]), 64'(ev));
                if (rvalid[d] && sbq[d].size() > 0) begin
                    e = sbq[d].pop_front();
                    chk("resp_cycle", d, 64'(cyc), 64'(e.due));
                    chk("resp_err_data", d, 64'({err[d], rdata[d]}), 64'({e.err, e.dat}));
                end else if (!rvalid[d] && ev) begin
                    void'(sbq[d].pop_front());
                end
                if (!rvalid[d]) chk("idle_zero", d, 64'({err[d], rdata[d]}), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bit    g;
        int    t;
        int    held_tries [4] = '{1, 1, 2, 1};
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; be[d] = 4'h0;
            wdata[d] = 32'h0; lwe[d] = 1'b0; la[d] = 32'h0; lwd[d] = 32'h0;
        end

        // Preload words 0..63 and 4095 under reset, with req held high to confirm gnt stays low.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w <= 64; w++) begin
                s     = mk(1'b1, 1'b0, 32'(w) << 2, 4'hF, 32'h0);
                s.rst = 1'b0;
                s.lwe = 1'b1;
                s.la  = ($urandom & 32'hFFFF_F000) | ((w == 64) ? 32'd4095 : 32'(w));
                s.lwd = (w == 0) ? 32'hDEAD_BEEF : (w == 1) ? 32'hAAAA_AAAA : $urandom;
                drive(d, s, g);
            end
        end
        for (int d = 0; d < 2; d++) drive(d, mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0), g);

        // Latency 1: preloaded read, masked write, back-to-back throughput, out-of-range.
        xact(0, mk(1'b1, 1'b0, 32'h0, 4'h0, 32'h0), t);
        xact(0, mk(1'b1, 1'b1, 32'h4, 4'b0101, 32'h1122_3344), t);
        xact(0, mk(1'b1, 1'b0, 32'h4, 4'h0, 32'h0), t);
        for (int i = 0; i < 8; i++) begin
            xact(0, mk(1'b1, 1'b0, 32'(i) << 2, 4'h0, 32'h0), t);
            chk("b2b_tries", 0, 64'(t), 64'd1);
        end
        xact(0, mk(1'b1, 1'b0, 32'h0000_4000, 4'h0, 32'h0), t);
        xact(0, mk(1'b1, 1'b1, 32'h0000_4000, 4'hF, 32'h5A5A_5A5A), t);
        xact(0, mk(1'b1, 1'b0, 32'h0, 4'h0, 32'h0), t);
        xact(0, mk(1'b1, 1'b0, 32'h4, 4'h0, 32'h0), t);
        xact(0, mk(1'b1, 1'b0, 32'h3FFC, 4'h0, 32'h0), t);
        idle(0, 4);

        // Latency 3, two outstanding: held request stalls on the third until a retire.
        for (int i = 0; i < 4; i++) begin
            xact(1, mk(1'b1, 1'b0, 32'(i) << 2, 4'h0, 32'h0), t);
            chk("held_tries", 1, 64'(t), 64'(held_tries[i]));
        end
        idle(1, 5);

        // Reset one cycle after two grants: responses vanish, gnt low, counter cleared.
        xact(1, mk(1'b1, 1'b0, 32'h10, 4'h0, 32'h0), t);
        xact(1, mk(1'b1, 1'b0, 32'h14, 4'h0, 32'h0), t);
        for (int i = 0; i < 3; i++) begin
            s     = mk(1'b1, 1'b0, 32'h18, 4'h0, 32'h0);
            s.rst = 1'b0;
            drive(1, s, g);
        end
        for (int i = 0; i < 4; i++) begin
            xact(1, mk(1'b1, 1'b0, 32'(i + 8) << 2, 4'h0, 32'h0), t);
            chk("post_reset_tries", 1, 64'(t), 64'(held_tries[i]));
        end
        idle(1, 5);

        // Random traffic with backdoor collisions and out-of-range accesses.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                int r;
                if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
                r = $urandom_range(0, 9);
                s = mk(1'b1, 1'($urandom_range(0, 1)), 32'h0, 4'($urandom_range(0, 15)), $urandom);
                if (r < 8)       s.a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
                else if (r == 8) s.a = 32'h3FFC | 32'($urandom_range(0, 3));
                else if ($urandom_range(0, 1) == 1) s.a = 32'h4000 + (32'($urandom_range(0, 1023)) << 2);
                else             s.a = $urandom | 32'h8000_0000;
                s.lwe = ($urandom_range(0, 4) == 0);
                s.la  = ($urandom & 32'hFFFF_F000) |
                        (($urandom_range(0, 1) == 1) ? {20'h0, s.a[13:2]} : 32'($urandom_range(0, 63)));
                s.lwd = $urandom;
                xact(d, s, t);
            end
            idle(d, 6);
        end

        for (int i = 0; i < 10 && (sbq[0].size() + sbq[1].size()) > 0; i++) @(negedge clk);
        chk("drain", 0, 64'(sbq[0].size() + sbq[1].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
